// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-port signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_raddr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_raddr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_raddr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// LSU has fixed priority; a starvation counter forces an IFU grant.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MASK_W         = 8,
  parameter int IFU_STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [7:0] STARVE_MAX = 8'(IFU_STARVE_MAX);

  logic [1:0]        state_r;
  logic              owner_lsu_r;
  logic [7:0]        starve_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic [DATA_W-1:0] rdata_r;
  logic              lsu_win_s;
  logic              ifu_win_s;

  // Arbitration; ready is withheld during reset so no handshake is claimed that the state cannot take.
  always_comb begin
    lsu_win_s = 1'b0;
    ifu_win_s = 1'b0;
    if ((state_r == S_IDLE) && !rst) begin
      if (bus.lsu_req_valid && !(bus.ifu_req_valid && (starve_cnt_r == STARVE_MAX))) begin
        lsu_win_s = 1'b1;
      end else if (bus.ifu_req_valid) begin
        ifu_win_s = 1'b1;
      end else begin
        lsu_win_s = 1'b0;
        ifu_win_s = 1'b0;
      end
    end else begin
      lsu_win_s = 1'b0;
      ifu_win_s = 1'b0;
    end
  end

  // Transaction FSM, request capture, starvation counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      owner_lsu_r  <= 1'b0;
      starve_cnt_r <= 8'd0;
      addr_r       <= '0;
      wen_r        <= 1'b0;
      wdata_r      <= '0;
      wmask_r      <= '0;
      rdata_r      <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (lsu_win_s) begin
            state_r     <= S_ISSUE;
            owner_lsu_r <= 1'b1;
            addr_r      <= bus.lsu_addr;
            wen_r       <= bus.lsu_wen;
            wdata_r     <= bus.lsu_wdata;
            wmask_r     <= bus.lsu_wmask;
            if (bus.ifu_req_valid && (starve_cnt_r < STARVE_MAX)) begin
              starve_cnt_r <= starve_cnt_r + 8'd1;
            end
          end else if (ifu_win_s) begin
            state_r      <= S_ISSUE;
            owner_lsu_r  <= 1'b0;
            addr_r       <= bus.ifu_raddr;
            wen_r        <= 1'b0;
            wdata_r      <= '0;
            wmask_r      <= '0;
            starve_cnt_r <= 8'd0;
          end
        end
        S_ISSUE: begin
          // A response in the handshake cycle is deliberately not captured.
          if (bus.mem_req_ready) begin
            state_r <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (bus.mem_resp_valid) begin
            rdata_r <= bus.mem_rdata;
            state_r <= S_RESP;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_win_s;
  assign bus.lsu_req_ready  = lsu_win_s;
  assign bus.mem_req_valid  = (state_r == S_ISSUE);
  assign bus.mem_addr       = addr_r;
  assign bus.mem_wen        = wen_r;
  assign bus.mem_wdata      = wdata_r;
  assign bus.mem_wmask      = wmask_r;
  assign bus.ifu_resp_valid = (state_r == S_RESP) && !owner_lsu_r;
  assign bus.lsu_resp_valid = (state_r == S_RESP) && owner_lsu_r;
  assign bus.ifu_rdata      = rdata_r;
  assign bus.lsu_rdata      = rdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, starvation guard,
// held write fields, stray responses and mid-transaction reset.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(8), .IFU_STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 1..3 of a granted transaction with an immediately ready memory,
  // then leaves the bench at the start of cycle 4 (next IDLE).
  task automatic serve(input string tag, input logic exp_lsu, input logic [31:0] d,
                       input logic keep_lsu, input logic keep_ifu);
    next_cycle();
    bus.lsu_req_valid = bus.lsu_req_valid & keep_lsu;
    bus.ifu_req_valid = bus.ifu_req_valid & keep_ifu;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check({tag, "_issue_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, "_issue_readies"}, 64'({bus.lsu_req_ready, bus.ifu_req_ready}), 64'd0);
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = d;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    @(negedge clk);
    check({tag, "_lsu_resp"}, 64'(bus.lsu_resp_valid), 64'(exp_lsu));
    check({tag, "_ifu_resp"}, 64'(bus.ifu_resp_valid), 64'(!exp_lsu));
    check({tag, "_rdata"}, 64'(exp_lsu ? bus.lsu_rdata : bus.ifu_rdata), 64'(d));
    next_cycle();
  endtask

  initial begin
    logic [9:0] ifu_turn;
    checks = 0;
    errors = 0;
    ifu_turn = 10'b10_0001_0000;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b0; bus.ifu_raddr = 32'h0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = 32'h0; bus.lsu_wmask = 8'h0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_resp", 64'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_starve", 64'(dut.starve_cnt_r), 64'd0);
    next_cycle();
    rst = 1'b0;

    // 1: IFU-only fetch, minimum latency
    bus.ifu_req_valid = 1'b1; bus.ifu_raddr = 32'h8000_0000;
    @(negedge clk);
    check("t1_ifu_ready", 64'(bus.ifu_req_ready), 64'd1);
    check("t1_lsu_ready", 64'(bus.lsu_req_ready), 64'd0);
    next_cycle();
    bus.ifu_req_valid = 1'b0; bus.ifu_raddr = 32'h0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check("t1_mem_valid", 64'(bus.mem_req_valid), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'h8000_0000);
    check("t1_mem_wen", 64'(bus.mem_wen), 64'd0);
    check("t1_mem_wmask_wdata", 64'({bus.mem_wmask, bus.mem_wdata}), 64'd0);
    next_cycle();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0000_0413;
    @(negedge clk);
    check("t1_wait_valid", 64'(bus.mem_req_valid), 64'd0);
    check("t1_c2_resp", 64'(bus.ifu_resp_valid), 64'd0);
    next_cycle();
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    check("t1_c3_resp", 64'(bus.ifu_resp_valid), 64'd1);
    check("t1_c3_rdata", 64'(bus.ifu_rdata), 64'h0000_0413);
    check("t1_c3_lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1_c4_resp", 64'(bus.ifu_resp_valid), 64'd0);
    next_cycle();

    // 2: simultaneous requests, LSU first, then IFU
    bus.ifu_req_valid = 1'b1; bus.ifu_raddr = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_0100; bus.lsu_wen = 1'b0;
    @(negedge clk);
    check("t2_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    check("t2_ifu_ready", 64'(bus.ifu_req_ready), 64'd0);
    serve("t2_lsu", 1'b1, 32'h0000_0011, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_starve_1", 64'(dut.starve_cnt_r), 64'd1);
    check("t2_ifu_ready2", 64'(bus.ifu_req_ready), 64'd1);
    serve("t2_ifu", 1'b0, 32'h0000_0022, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_starve_0", 64'(dut.starve_cnt_r), 64'd0);
    next_cycle();

    // 3: continuous contention -> L,L,L,L,I,L,L,L,L,I
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      check($sformatf("t3_g%0d_starve", g), 64'(dut.starve_cnt_r), 64'(g % 5));
      check($sformatf("t3_g%0d_lsu_ready", g), 64'(bus.lsu_req_ready), 64'(!ifu_turn[g]));
      check($sformatf("t3_g%0d_ifu_ready", g), 64'(bus.ifu_req_ready), 64'(ifu_turn[g]));
      serve($sformatf("t3_g%0d", g), !ifu_turn[g], 32'h100 + 32'(g), 1'b1, 1'b1);
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    next_cycle();

    // 4: LSU write with delayed mem_req_ready; 5: stray responses in ISSUE and handshake cycle
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1'b1;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 8'h0F;
    @(negedge clk);
    check("t4_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    next_cycle();
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = 32'h1234_5678; bus.lsu_wmask = 8'hFF;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
      end
      @(negedge clk);
      check($sformatf("t4_k%0d_valid", k), 64'(bus.mem_req_valid), 64'd1);
      check($sformatf("t4_k%0d_addr", k), 64'(bus.mem_addr), 64'h8000_1000);
      check($sformatf("t4_k%0d_wdata", k), 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      check($sformatf("t4_k%0d_wmask_wen", k), 64'({bus.mem_wmask, bus.mem_wen}), 64'h1F);
      check($sformatf("t4_k%0d_resp", k), 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'd0);
      next_cycle();
      bus.mem_resp_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    check("t4_wait_valid", 64'(bus.mem_req_valid), 64'd0);
    check("t4_wait_resp", 64'(bus.lsu_resp_valid), 64'd0);
    next_cycle();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    next_cycle();
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    check("t4_resp", 64'(bus.lsu_resp_valid), 64'd1);
    check("t4_rdata", 64'(bus.lsu_rdata), 64'hCAFE_F00D);
    check("t4_ifu_resp", 64'(bus.ifu_resp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t4_resp_once", 64'(bus.lsu_resp_valid), 64'd0);

    // 5: stray responses in IDLE
    next_cycle();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("t5_k%0d_resp", k), 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'd0);
      check($sformatf("t5_k%0d_valid", k), 64'(bus.mem_req_valid), 64'd0);
      next_cycle();
    end
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    check("t5_after_resp", 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'd0);
    check("t5_after_valid", 64'(bus.mem_req_valid), 64'd0);
    next_cycle();

    // 6: reset while waiting for the response
    bus.ifu_req_valid = 1'b1; bus.ifu_raddr = 32'h8000_0040;
    @(negedge clk);
    check("t6_ifu_ready", 64'(bus.ifu_req_ready), 64'd1);
    next_cycle();
    bus.ifu_req_valid = 1'b0; bus.ifu_raddr = 32'h0; bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t6_wait_valid", 64'(bus.mem_req_valid), 64'd0);
    next_cycle();
    rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0000_0099;
    @(negedge clk);
    check("t6_post_valid", 64'(bus.mem_req_valid), 64'd0);
    check("t6_post_addr", 64'(bus.mem_addr), 64'd0);
    check("t6_post_rdata", 64'(bus.ifu_rdata), 64'd0);
    check("t6_post_resp", 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'd0);
    check("t6_post_ready", 64'({bus.lsu_req_ready, bus.ifu_req_ready}), 64'd0);
    next_cycle();
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    check("t6_late_resp", 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'd0);
    next_cycle();
    bus.ifu_req_valid = 1'b1; bus.ifu_raddr = 32'h8000_0044;
    @(negedge clk);
    check("t6_recover_ready", 64'(bus.ifu_req_ready), 64'd1);
    serve("t6_recover", 1'b0, 32'h0000_0777, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
